// File: rtl/barrel_pkg.sv
// Shared constants and reference rotate functions for the barrel rotator family.
// Reference functions are for scoreboards only; the datapath builds its own muxes.
package barrel_pkg;

    localparam int BR_WIDTH = 8;

    typedef logic [BR_WIDTH-1:0] br_word_t;

    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

    function automatic br_word_t rotl_ref(input br_word_t a, input int unsigned k);
        int unsigned m;
        m = k % BR_WIDTH;
        return br_word_t'((a << m) | (a >> (BR_WIDTH - m)));
    endfunction

    function automatic br_word_t rotr_ref(input br_word_t a, input int unsigned k);
        int unsigned m;
        m = k % BR_WIDTH;
        return br_word_t'((a >> m) | (a << (BR_WIDTH - m)));
    endfunction

endpackage

// File: rtl/barrel_rotl_pipe_if.sv
// Valid/ready word bus for the pipelined left rotator; slave is the rotator side,
// master is whoever drives the input word and the downstream ready.
interface barrel_rotl_pipe_if
    import barrel_pkg::*;
#(
    parameter int WIDTH = BR_WIDTH
);
    localparam int SHAMT_W = shamt_w(WIDTH);

    logic               i_valid;
    logic               o_ready;
    logic [WIDTH-1:0]   i_A;
    logic [SHAMT_W-1:0] i_k;
    logic               o_valid;
    logic               i_ready;
    logic [WIDTH-1:0]   o_Y;

    modport master (
        output i_valid, i_A, i_k, i_ready,
        input  o_ready, o_valid, o_Y
    );

    modport slave (
        input  i_valid, i_A, i_k, i_ready,
        output o_ready, o_valid, o_Y
    );

endinterface

// File: rtl/barrel_rotl_pipe_stage.sv
// One rotate-left-by-SH mux stage with registered data/valid/remaining shift; 1 cycle.
// Holds its word while full and the next stage is not taking it; loads freely when empty.
module rotl_stage
    import barrel_pkg::*;
#(
    parameter  int WIDTH   = BR_WIDTH,
    parameter  int SH      = 1,
    localparam int SHAMT_W = shamt_w(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    input  logic               adv_dn,
    input  logic [WIDTH-1:0]   in_dat,
    input  logic [SHAMT_W-1:0] in_sh,
    output logic               out_vld,
    output logic [WIDTH-1:0]   out_dat,
    output logic [SHAMT_W-1:0] out_sh
);

    logic             load;
    logic [WIDTH-1:0] rot_dat;

    assign load = !out_vld || adv_dn;

    // The MSB of the remaining shift field is always the bit this stage owns.
    assign rot_dat = in_sh[SHAMT_W-1] ? ((in_dat << SH) | (in_dat >> (WIDTH - SH))) : in_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_sh  <= '0;
        end else if (load) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= rot_dat;
                out_sh  <= in_sh << 1;
            end
        end
    end

endmodule

// File: rtl/barrel_rotl_pipe.sv
// Pipelined rotate-left, o_Y[i] = i_A[(i-k) mod WIDTH]; SHAMT_W cycles, one word/cycle.
// Combinational ready chain with bubble collapse; holds o_Y stable while downstream stalls.
module barrel_rotl_pipe
    import barrel_pkg::*;
#(
    parameter  int WIDTH   = BR_WIDTH,
    localparam int SHAMT_W = shamt_w(WIDTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    barrel_rotl_pipe_if.slave bus
);

    logic [SHAMT_W:0]   vld;
    logic [WIDTH-1:0]   dat [0:SHAMT_W];
    logic [SHAMT_W-1:0] sh  [0:SHAMT_W];
    logic [SHAMT_W+1:1] load;

    assign vld[0] = bus.i_valid;
    assign dat[0] = bus.i_A;
    assign sh[0]  = bus.i_k;

    assign load[SHAMT_W+1] = bus.i_ready;

    // Stage s loads unless it and every stage after it are full while downstream stalls.
    for (genvar s = 1; s <= SHAMT_W; s++) begin : g_load
        assign load[s] = bus.i_ready || !(&vld[SHAMT_W:s]);
    end

    for (genvar s = 1; s <= SHAMT_W; s++) begin : g_stage
        rotl_stage #(
            .WIDTH (WIDTH),
            .SH    (WIDTH >> s)
        ) u_stage (
            .clk     (i_clk),
            .rst     (i_rst),
            .in_vld  (vld[s-1]),
            .adv_dn  (load[s+1]),
            .in_dat  (dat[s-1]),
            .in_sh   (sh[s-1]),
            .out_vld (vld[s]),
            .out_dat (dat[s]),
            .out_sh  (sh[s])
        );
    end

    assign bus.o_ready = load[1] && !i_rst;
    assign bus.o_valid = vld[SHAMT_W];
    assign bus.o_Y     = dat[SHAMT_W];

endmodule

// File: tb/tb_barrel_rotl_pipe.sv
// Directed bench for barrel_rotl_pipe: latency, boundary amounts, backpressure,
// pass-through, mid-flight reset and a randomised full round trip.
module tb_barrel_rotl_pipe;
    import barrel_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    barrel_rotl_pipe_if bus ();

    barrel_rotl_pipe dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] bp_a [5] = '{8'h12, 8'hF0, 8'h81, 8'h7E, 8'hC3};
    logic [2:0] bp_k [5] = '{3'd3,  3'd5,  3'd6,  3'd2,  3'd1};
    logic [7:0] bp_y [5] = '{8'h90, 8'h1E, 8'h60, 8'hF9, 8'h87};

    int         acc;
    int         got;
    int         sent;
    logic       in_x;
    logic       out_x;
    logic [7:0] ea;
    logic [2:0] ek;
    logic [7:0] qa [$];
    logic [2:0] qk [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [2:0] k);
        bus.i_valid = v;
        bus.i_A     = a;
        bus.i_k     = k;
    endtask

    function automatic logic [7:0] m_rotl(input logic [7:0] a, input int k);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[(i + k) % 8] = a[i];
        return r;
    endfunction

    function automatic logic [7:0] pa(input int j);
        return 8'(j * 37 + 5);
    endfunction

    initial begin
        rst         = 1'b1;
        bus.i_ready = 1'b0;
        drive(1'b0, 8'h00, 3'd0);
        tick();
        chk("rst_ready_low", bus.o_ready, 0);
        tick();
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_y", bus.o_Y, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus.o_ready, 1);

        // Single word: accepted on the first edge, visible after the third.
        bus.i_ready = 1'b1;
        drive(1'b1, 8'b1000_0001, 3'd1);
        tick();
        drive(1'b0, 8'h00, 3'd0);
        chk("t1_edge1_vld", bus.o_valid, 0);
        tick();
        chk("t1_edge2_vld", bus.o_valid, 0);
        tick();
        chk("t1_edge3_vld", bus.o_valid, 1);
        chk("t1_y", bus.o_Y, 8'b0000_0011);
        tick();
        chk("t1_after_vld", bus.o_valid, 0);

        // Boundary amounts back to back.
        drive(1'b1, 8'hA5, 3'd4);
        tick();
        drive(1'b1, 8'h01, 3'd7);
        tick();
        drive(1'b1, 8'h3C, 3'd0);
        tick();
        drive(1'b0, 8'h00, 3'd0);
        chk("b2b_vld0", bus.o_valid, 1);
        chk("b2b_y0", bus.o_Y, 8'h5A);
        tick();
        chk("b2b_vld1", bus.o_valid, 1);
        chk("b2b_y1", bus.o_Y, 8'h80);
        tick();
        chk("b2b_vld2", bus.o_valid, 1);
        chk("b2b_y2", bus.o_Y, 8'h3C);
        tick();
        chk("b2b_empty", bus.o_valid, 0);

        // Backpressure: capacity of three, then a held output while stalled.
        bus.i_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, bp_a[acc], bp_k[acc]);
            #1;
            chk("bp_ready", bus.o_ready, (c < 3));
            if (c >= 3) begin
                chk("bp_hold_vld", bus.o_valid, 1);
                chk("bp_hold_y", bus.o_Y, bp_y[0]);
            end
            if (bus.o_ready) acc++;
            tick();
        end
        chk("bp_accepted", acc, 3);
        bus.i_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (acc < 5) drive(1'b1, bp_a[acc], bp_k[acc]);
            else drive(1'b0, 8'h00, 3'd0);
            #1;
            if (bus.o_valid) begin
                chk("bp_drain_y", bus.o_Y, bp_y[got]);
                got++;
            end
            if (bus.i_valid && bus.o_ready) acc++;
            tick();
        end
        chk("bp_drain_count", got, 5);
        chk("bp_drained_empty", bus.o_valid, 0);

        // Full pipeline pass-through: ten words, one per cycle.
        drive(1'b1, pa(0), 3'd0);
        #1;
        chk("pt_ready", bus.o_ready, 1);
        for (int t = 1; t <= 14; t++) begin
            tick();
            chk("pt_vld", bus.o_valid, (t >= 3 && t <= 12));
            if (t >= 3 && t <= 12) chk("pt_y", bus.o_Y, m_rotl(pa(t - 3), (t - 3) % 8));
            if (t < 10) drive(1'b1, pa(t), 3'(t % 8));
            else drive(1'b0, 8'h00, 3'd0);
            #1;
            if (t < 10) chk("pt_ready", bus.o_ready, 1);
        end

        // Reset with three words in flight.
        bus.i_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, bp_a[j], bp_k[j]);
            tick();
        end
        drive(1'b0, 8'h00, 3'd0);
        chk("mr_pre_vld", bus.o_valid, 1);
        rst = 1'b1;
        #1;
        chk("mr_ready_low", bus.o_ready, 0);
        tick();
        rst = 1'b0;
        chk("mr_vld", bus.o_valid, 0);
        chk("mr_y", bus.o_Y, 0);
        bus.i_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("mr_no_stale", bus.o_valid, 0);
        end

        // Round trip of every value and amount under random handshakes.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 20000 && got < 2048; c++) begin
            if (!bus.i_valid && sent < 2048 && $urandom_range(0, 3) != 0)
                drive(1'b1, 8'(sent), 3'(sent >> 8));
            bus.i_ready = ($urandom_range(0, 3) != 0);
            #1;
            in_x  = bus.i_valid && bus.o_ready;
            out_x = bus.o_valid && bus.i_ready;
            if (out_x) begin
                if (qa.size() == 0) begin
                    chk("rt_spurious", bus.o_valid, 0);
                end else begin
                    ea = qa.pop_front();
                    ek = qk.pop_front();
                    chk("rt_rotl", bus.o_Y, m_rotl(ea, ek));
                    chk("rt_roundtrip", rotr_ref(bus.o_Y, ek), ea);
                    got++;
                end
            end
            if (in_x) begin
                qa.push_back(bus.i_A);
                qk.push_back(bus.i_k);
                sent++;
            end
            @(posedge clk);
            #1;
            if (in_x) bus.i_valid = 1'b0;
        end
        chk("rt_sent", sent, 2048);
        chk("rt_count", got, 2048);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
